// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - value load and display pin bundle for seg7_scan_mux
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value_in;
    logic [DIGITS-1:0]     dp_in;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  update_pending;
    logic                  frame_done;

    // master: measurement datapath side; slave: the display driver
    modport master (
        output load, value_in, dp_in,
        input  seg, an, update_pending, frame_done
    );

    modport slave (
        input  load, value_in, dp_in,
        output seg, an, update_pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed 7-segment scanner with frame-synchronous value commit
module seg7_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 100000,
    parameter int HEX_MODE = 0,
    parameter int LZ_BLANK = 1
) (
    input  logic            clk,
    input  logic            reset,
    seg7_scan_mux_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  disp_val_q, disp_val_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]  shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic              pending_q, pending_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              tick;
    logic              boundary;
    logic [DIGITS-1:0] blank;
    logic              run;
    logic [3:0]        nib_sel;
    logic              dp_sel;
    logic              blank_sel;
    logic [DIGITS-1:0] an_sel;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'b0000_0011;
            4'h1:    g = 8'b1001_1111;
            4'h2:    g = 8'b0010_0101;
            4'h3:    g = 8'b0000_1101;
            4'h4:    g = 8'b1001_1001;
            4'h5:    g = 8'b0100_1001;
            4'h6:    g = 8'b0100_0001;
            4'h7:    g = 8'b0001_1111;
            4'h8:    g = 8'b0000_0001;
            4'h9:    g = 8'b0000_1001;
            4'hA:    g = (HEX_MODE != 0) ? 8'b0001_0001 : 8'hFF;
            4'hB:    g = (HEX_MODE != 0) ? 8'b1100_0001 : 8'hFF;
            4'hC:    g = (HEX_MODE != 0) ? 8'b0110_0011 : 8'hFF;
            4'hD:    g = (HEX_MODE != 0) ? 8'b1000_0101 : 8'hFF;
            4'hE:    g = (HEX_MODE != 0) ? 8'b0110_0001 : 8'hFF;
            default: g = (HEX_MODE != 0) ? 8'b0111_0001 : 8'hFF;
        endcase
        return g;
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // State register: divider, scan index, buffers and registered pins
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            idx_q        <= IDX_LAST;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    // Next state: scan position and double-buffered value
    always_comb begin
        div_d        = tick ? '0 : div_q + 1'b1;
        idx_d        = idx_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        frame_done_d = boundary;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (boundary) begin
            // a load coinciding with the boundary bypasses the shadow
            pending_d = 1'b0;
            if (bus.load) begin
                disp_val_d = bus.value_in;
                disp_dp_d  = bus.dp_in;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end else if (bus.load) begin
            shadow_val_d = bus.value_in;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
    end

    // Output: the digit being entered is rendered from the post-edge value
    always_comb begin
        blank = '0;
        run   = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            run      = run & (disp_val_d[4*j +: 4] == 4'h0) & ~disp_dp_d[j];
            blank[j] = (LZ_BLANK != 0) && (j != 0) && run;
        end

        nib_sel   = disp_val_d[3:0];
        dp_sel    = disp_dp_d[0];
        blank_sel = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib_sel   = disp_val_d[4*i +: 4];
                dp_sel    = disp_dp_d[i];
                blank_sel = blank[i];
                an_sel[i] = 1'b0;
            end
        end

        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            if (blank_sel) begin
                seg_d = 8'hFF;
                an_d  = '1;
            end else begin
                seg_d = glyph(nib_sel) & {7'h7F, ~dp_sel};
                an_d  = an_sel;
            end
        end
    end

    assign bus.seg            = seg_q;
    assign bus.an             = an_q;
    assign bus.update_pending = pending_q;
    assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - randomized and directed bench for seg7_scan_mux
module tb_seg7_scan_mux;
    localparam int NC = 3;
    localparam int DIGS [NC] = '{4, 4, 3};
    localparam int CDIV [NC] = '{4, 4, 1};
    localparam int HEXM [NC] = '{0, 1, 1};
    localparam int LZB  [NC] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    seg7_scan_mux_if #(.DIGITS(4)) ifa ();
    seg7_scan_mux_if #(.DIGITS(4)) ifb ();
    seg7_scan_mux_if #(.DIGITS(3)) ifc ();

    assign ifa.load = load;  assign ifa.value_in = value_in;        assign ifa.dp_in = dp_in;
    assign ifb.load = load;  assign ifb.value_in = value_in;        assign ifb.dp_in = dp_in;
    assign ifc.load = load;  assign ifc.value_in = value_in[11:0];  assign ifc.dp_in = dp_in[2:0];

    seg7_scan_mux #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .LZ_BLANK(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    seg7_scan_mux #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .LZ_BLANK(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    seg7_scan_mux #(.DIGITS(3), .CLK_DIV(1), .HEX_MODE(1), .LZ_BLANK(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [7:0] o_seg [NC];
    logic [7:0] o_an  [NC];
    logic       o_pend[NC];
    logic       o_fd  [NC];
    always_comb begin
        o_seg[0] = ifa.seg; o_an[0] = {4'h0, ifa.an}; o_pend[0] = ifa.update_pending; o_fd[0] = ifa.frame_done;
        o_seg[1] = ifb.seg; o_an[1] = {4'h0, ifb.an}; o_pend[1] = ifb.update_pending; o_fd[1] = ifb.frame_done;
        o_seg[2] = ifc.seg; o_an[2] = {5'h0, ifc.an}; o_pend[2] = ifc.update_pending; o_fd[2] = ifc.frame_done;
    end

    // Reference model: edge count since reset decides which digit is on
    int          m_n;
    logic [15:0] m_dv [NC];
    logic [3:0]  m_dd [NC];
    logic [15:0] m_sv [NC];
    logic [3:0]  m_sd [NC];
    logic        m_pend[NC];
    logic        m_fd  [NC];
    logic        m_tick[NC];
    int          m_s   [NC];
    logic [7:0]  m_seg [NC];
    logic [7:0]  m_an  [NC];

    function automatic logic [7:0] ref_glyph(input int nib, input int hx);
        logic [7:0] t [16];
        t = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
              8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
              8'b0000_0001, 8'b0000_1001, 8'b0001_0001, 8'b1100_0001,
              8'b0110_0011, 8'b1000_0101, 8'b0110_0001, 8'b0111_0001};
        if (nib >= 10 && hx == 0) return 8'hFF;
        return t[nib];
    endfunction

    task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d);
        for (int k = 0; k < NC; k++) begin
            logic [15:0] vm;
            logic [3:0]  dm;
            logic [7:0]  amask;
            vm    = v & 16'((32'h1 << (4 * DIGS[k])) - 1);
            dm    = d & 4'((1 << DIGS[k]) - 1);
            amask = 8'((1 << DIGS[k]) - 1);
            if (reset) begin
                m_dv[k] = '0; m_dd[k] = '0; m_sv[k] = '0; m_sd[k] = '0;
                m_pend[k] = 1'b0; m_fd[k] = 1'b0; m_tick[k] = 1'b0;
                m_s[k] = DIGS[k] - 1; m_seg[k] = 8'hFF; m_an[k] = amask;
            end else begin
                m_tick[k] = ((m_n + 1) % CDIV[k]) == 0;
                m_fd[k]   = 1'b0;
                if (m_tick[k]) m_s[k] = ((m_n + 1) / CDIV[k] - 1) % DIGS[k];
                if (m_tick[k] && m_s[k] == 0) begin
                    if (ld) begin m_dv[k] = vm; m_dd[k] = dm; end
                    else if (m_pend[k]) begin m_dv[k] = m_sv[k]; m_dd[k] = m_sd[k]; end
                    m_pend[k] = 1'b0;
                    m_fd[k]   = 1'b1;
                end else if (ld) begin
                    m_sv[k] = vm; m_sd[k] = dm; m_pend[k] = 1'b1;
                end
                if (m_tick[k]) begin
                    if (LZB[k] != 0 && m_s[k] != 0 && (m_dv[k] >> (4 * m_s[k])) == 0 && (m_dd[k] >> m_s[k]) == 0) begin
                        m_seg[k] = 8'hFF;
                        m_an[k]  = amask;
                    end else begin
                        m_seg[k] = ref_glyph(int'((m_dv[k] >> (4 * m_s[k])) & 16'hF), HEXM[k]);
                        if (m_dd[k][m_s[k]]) m_seg[k][0] = 1'b0;
                        m_an[k] = amask & ~(8'h1 << m_s[k]);
                    end
                end
            end
        end
        m_n = reset ? 0 : m_n + 1;
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        load = ld; value_in = v; dp_in = d;
        @(posedge clk);
        model_edge(ld, v, d);
        #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        reset = 1'b0;
    endtask

    task automatic run_to_digit(input int d);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 16'h0, 4'h0);
            if (m_tick[0] && m_s[0] == d) break;
        end
    endtask

    task automatic run_to_pre_boundary();
        for (int i = 0; i < 64; i++) begin
            if (((m_n + 1) % CDIV[0]) == 0 && (((m_n + 1) / CDIV[0] - 1) % DIGS[0]) == 0) break;
            step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < NC; k++) begin
            n_tests++;
            if (o_seg[k] !== 8'hFF || o_an[k] !== 8'((1 << DIGS[k]) - 1) || o_pend[k] !== 1'b0 || o_fd[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: seg=%b an=%b pend=%b fd=%b, expected seg=ff an=all1 pend=0 fd=0", k, o_seg[k], o_an[k], o_pend[k], o_fd[k]);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [3:0] ea [4];
        logic [7:0] es [4];
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        es = '{8'b1001_1001, 8'b0000_1101, 8'b0010_0101, 8'b1001_1111};
        do_reset();
        step(1'b1, 16'h1234, 4'h0);
        for (int e = 2; e <= 3; e++) begin
            step(1'b0, 16'h0, 4'h0);
            n_tests++;
            if (ifa.seg !== 8'hFF || ifa.an !== 4'hF || ifa.update_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_pre_tick edge%0d: seg=%b an=%b pend=%b, expected ff/1111/1", e, ifa.seg, ifa.an, ifa.update_pending);
            end
        end
        for (int f = 0; f < 4; f++) begin
            repeat ((f == 0) ? 1 : 4) step(1'b0, 16'h0, 4'h0);
            n_tests++;
            if (ifa.an !== ea[f] || ifa.seg !== es[f] || ifa.frame_done !== (f == 0)) begin
                n_fail++;
                $display("FAIL basic_scan edge%0d: an=%b seg=%b fd=%b, expected an=%b seg=%b fd=%b", 4 * (f + 1), ifa.an, ifa.seg, ifa.frame_done, ea[f], es[f], f == 0);
            end
        end
        repeat (4) step(1'b0, 16'h0, 4'h0);
        n_tests++;
        if (ifa.frame_done !== 1'b1 || ifa.an !== 4'b1110) begin
            n_fail++;
            $display("FAIL basic_frame2 edge20: fd=%b an=%b, expected fd=1 an=1110", ifa.frame_done, ifa.an);
        end
    endtask

    task automatic test_lz_blank();
        step(1'b1, 16'h0007, 4'h0);
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'b0001_1111 || ifa.an !== 4'b1110) begin
            n_fail++;
            $display("FAIL lz_digit0: seg=%b an=%b, expected 00011111/1110", ifa.seg, ifa.an);
        end
        for (int d = 1; d < 4; d++) begin
            run_to_digit(d);
            n_tests++;
            if (ifa.seg !== 8'hFF || ifa.an !== 4'hF) begin
                n_fail++;
                $display("FAIL lz_blank digit%0d: seg=%b an=%b, expected ff/1111", d, ifa.seg, ifa.an);
            end
        end
        step(1'b1, 16'h0000, 4'h0);
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'b0000_0011 || ifa.an !== 4'b1110) begin
            n_fail++;
            $display("FAIL lz_zero digit0: seg=%b an=%b, expected 00000011/1110", ifa.seg, ifa.an);
        end
        run_to_digit(1);
        n_tests++;
        if (ifa.an !== 4'hF) begin
            n_fail++;
            $display("FAIL lz_zero digit1: an=%b, expected 1111", ifa.an);
        end
    endtask

    task automatic test_dp();
        step(1'b1, 16'h0005, 4'b0010);
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'b0100_1001) begin
            n_fail++;
            $display("FAIL dp_digit0: seg=%b, expected 01001001", ifa.seg);
        end
        run_to_digit(1);
        n_tests++;
        if (ifa.seg !== 8'b0000_0010 || ifa.an !== 4'b1101) begin
            n_fail++;
            $display("FAIL dp_digit1: seg=%b an=%b, expected 00000010/1101", ifa.seg, ifa.an);
        end
        for (int d = 2; d < 4; d++) begin
            run_to_digit(d);
            n_tests++;
            if (ifa.seg !== 8'hFF || ifa.an !== 4'hF) begin
                n_fail++;
                $display("FAIL dp_blank digit%0d: seg=%b an=%b, expected ff/1111", d, ifa.seg, ifa.an);
            end
        end
    endtask

    task automatic test_no_tearing();
        step(1'b1, 16'h2222, 4'h0);
        run_to_digit(0);
        run_to_digit(1);
        step(1'b1, 16'h1111, 4'h0);
        for (int d = 2; d < 4; d++) begin
            run_to_digit(d);
            n_tests++;
            if (ifa.seg !== 8'b0010_0101 || ifa.update_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL tearing digit%0d: seg=%b pend=%b, expected 00100101/1", d, ifa.seg, ifa.update_pending);
            end
        end
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'b1001_1111 || ifa.frame_done !== 1'b1 || ifa.update_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL tearing_commit: seg=%b fd=%b pend=%b, expected 10011111/1/0", ifa.seg, ifa.frame_done, ifa.update_pending);
        end
        run_to_pre_boundary();
        step(1'b1, 16'h9999, 4'h0);
        n_tests++;
        if (ifa.seg !== 8'b0000_1001 || ifa.frame_done !== 1'b1 || ifa.update_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_load: seg=%b fd=%b pend=%b, expected 00001001/1/0", ifa.seg, ifa.frame_done, ifa.update_pending);
        end
        run_to_digit(3);
        n_tests++;
        if (ifa.seg !== 8'b0000_1001 || ifa.update_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_load digit3: seg=%b pend=%b, expected 00001001/0", ifa.seg, ifa.update_pending);
        end
    endtask

    task automatic test_hex();
        step(1'b1, 16'h000A, 4'h0);
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'hFF || ifb.seg !== 8'b0001_0001 || ifb.an !== 4'b1110) begin
            n_fail++;
            $display("FAIL hex_A: dec seg=%b hex seg=%b hex an=%b, expected ff/00010001/1110", ifa.seg, ifb.seg, ifb.an);
        end
        step(1'b1, 16'h00F0, 4'h0);
        run_to_digit(0);
        n_tests++;
        if (ifb.seg !== 8'b0000_0011) begin
            n_fail++;
            $display("FAIL hex_F0 digit0: seg=%b, expected 00000011", ifb.seg);
        end
        run_to_digit(1);
        n_tests++;
        if (ifb.seg !== 8'b0111_0001 || ifb.an !== 4'b1101 || ifa.seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL hex_F0 digit1: hex seg=%b an=%b dec seg=%b, expected 01110001/1101/ff", ifb.seg, ifb.an, ifa.seg);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h1234, 4'h0);
        run_to_digit(0);
        run_to_digit(2);
        step(1'b1, 16'h5678, 4'h3);
        reset = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        reset = 1'b0;
        n_tests++;
        if (ifa.seg !== 8'hFF || ifa.an !== 4'hF || ifa.update_pending !== 1'b0 || ifa.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: seg=%b an=%b pend=%b fd=%b, expected ff/1111/0/0", ifa.seg, ifa.an, ifa.update_pending, ifa.frame_done);
        end
        run_to_digit(0);
        n_tests++;
        if (ifa.seg !== 8'b0000_0011 || ifa.an !== 4'b1110 || ifa.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_frame digit0: seg=%b an=%b fd=%b, expected 00000011/1110/1", ifa.seg, ifa.an, ifa.frame_done);
        end
        for (int d = 1; d < 4; d++) begin
            run_to_digit(d);
            n_tests++;
            if (ifa.seg !== 8'hFF || ifa.an !== 4'hF) begin
                n_fail++;
                $display("FAIL reset_mid_frame digit%0d: seg=%b an=%b, expected ff/1111", d, ifa.seg, ifa.an);
            end
        end
    endtask

    task automatic test_random();
        logic        ld;
        logic [15:0] v;
        logic [3:0]  d;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ld = ($urandom_range(0, 4) == 0);
            v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            d  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            reset = ($urandom_range(0, 399) == 0);
            step(ld, v, d);
            reset = 1'b0;
            for (int k = 0; k < NC; k++) begin
                n_tests++;
                if (o_seg[k] !== m_seg[k] || o_an[k] !== m_an[k] || o_pend[k] !== m_pend[k] || o_fd[k] !== m_fd[k]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: seg=%b an=%b pend=%b fd=%b, expected seg=%b an=%b pend=%b fd=%b",
                             k, i, o_seg[k], o_an[k], o_pend[k], o_fd[k], m_seg[k], m_an[k], m_pend[k], m_fd[k]);
                end
            end
        end
    endtask

    initial begin
        m_n = 0;
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_dp();
        test_no_tearing();
        test_hex();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for a DIGITS-digit common-anode 7-segment display. It holds a packed multi-digit BCD/hex value, scans one digit per refresh tick, and applies leading-zero blanking and per-digit decimal points. Value updates are double-buffered and commit only at frame boundaries, so a displayed frame never mixes old and new digits. It sits between the level-measurement datapath and the board display pins.

## Interface
- DIGITS, 4: number of digits, 1..8; digit 0 is the rightmost and least significant.
- CLK_DIV, 100000: clk cycles per scan step, ≥1.
- HEX_MODE, 0: 1 = nibbles 10–15 are shown as A–F; 0 = they are blanked.
- LZ_BLANK, 1: 1 = leading-zero blanking is enabled.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle strobe that captures value_in and dp_in.
- value_in  in  4*DIGITS  packed nibbles; digit i is value_in[4i+3:4i].
- dp_in  in  DIGITS  decimal point request per digit; 1 = lit.
- seg  out  8  {a,b,c,d,e,f,g,dp}, active-low, registered.
- an  out  DIGITS  anode enables, active-low, one-hot-low or all 1, registered.
- update_pending  out  1  shadow register holds a value that has not yet been committed.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Divider: div counts 0..CLK_DIV-1 and wraps. tick = (div == CLK_DIV-1).
- Scan index idx: resets to DIGITS-1. On each tick, idx advances by 1 modulo DIGITS. A tick that takes idx from DIGITS-1 to 0 is a frame boundary.
- Load, not on a frame boundary: shadow ← {value_in, dp_in} and update_pending ← 1. If several loads arrive before a boundary, the last one wins.
- Frame boundary:
  - If load is high in the same cycle, disp ← the live value_in/dp_in.
  - Else, if update_pending is set, disp ← shadow.
  - Else, disp is unchanged.
  - In all three cases, update_pending ← 0 and frame_done = 1 for that cycle.
- Blanking, computed on disp:
  - Digit i is blanked when LZ_BLANK = 1 and i ≠ 0 and, for every digit j with i ≤ j ≤ DIGITS-1, nibble j = 0 and dp j = 0.
  - A set dp therefore ends the blanking run. Digit 0 is never blanked.
- Segment codes, active-low, listed as a..g,dp:
  - 0 = 0000_0011, 1 = 1001_1111, 2 = 0010_0101, 3 = 0000_1101, 4 = 1001_1001
  - 5 = 0100_1001, 6 = 0100_0001, 7 = 0001_1111, 8 = 0000_0001, 9 = 0000_1001
  - With HEX_MODE = 1: A = 0001_0001, b = 1100_0001, C = 0110_0011, d = 1000_0101, E = 0110_0001, F = 0111_0001.
  - With HEX_MODE = 0: nibbles 10–15 = 1111_1111.
- Decimal point: if dp_in bit i is set, seg[0] ← 0 on top of the glyph for digit i.
- Blanked digit: seg = 1111_1111 and an = all 1. The anode is not driven.
- Shown digit: an[idx] = 0; all other an bits = 1.

## Timing
- Reset values, held from the first clk edge with reset high:
  - div = 0, idx = DIGITS-1, disp = 0, shadow = 0.
  - seg = 8'hFF, an = all 1, update_pending = 0, frame_done = 0.
- seg and an are registered from the post-tick idx. They change on the same edge at which idx advances and are stable between ticks.
- Between reset release and the first tick, seg and an stay at their reset values.
- The first tick after reset release is a frame boundary. It falls on the CLK_DIV-th rising edge after reset deasserts, and that edge displays digit 0.
- Frame period = DIGITS*CLK_DIV cycles. frame_done rises on the same edge at which digit 0 appears.
- Load-to-display latency: from the loaded edge to the next frame boundary, at most DIGITS*CLK_DIV cycles. update_pending is high from the edge after load until the boundary edge.
- CLK_DIV = 1: tick occurs every cycle and the digit changes every cycle.
- Reset mid-frame: on the next edge, all state and outputs return to reset values and any pending load is discarded.

## Test plan
- Basic scan. DIGITS=4, CLK_DIV=4. Reset, then load 0x1234 with dp_in=0 before the first tick.
  - Edge 4: an=1110, seg=1001_1001, frame_done=1.
  - Edge 8: an=1101, seg=0000_1101.
  - Edge 12: an=1011, seg=0010_0101.
  - Edge 16: an=0111, seg=1001_1111.
  - Edge 20: frame_done pulses again.
- Leading-zero blanking.
  - Value 0x0007: digits 3..1 give an=1111, seg=FF; digit 0 gives seg=0001_1111.
  - Value 0x0000: only digit 0 lights, seg=0000_0011.
- Decimal point. Value 0x0005, dp_in=0010.
  - Digit 1 shows seg=0000_0010.
  - Digit 0 shows seg=0100_1001.
  - Digits 3..2 are blanked.
- No tearing. Display 0x2222, then load 0x1111 while idx=1.
  - Digits 2 and 3 still show 2, i.e. 0010_0101.
  - update_pending=1 until the next frame_done; digit 0 then shows 1001_1111.
  - Also, load 0x9999 in the exact boundary cycle: that frame shows 9, and update_pending stays 0.
- HEX_MODE. Value 0x000A.
  - HEX_MODE=0: digit 0 seg=FF.
  - HEX_MODE=1: digit 0 seg=0001_0001.
  - With HEX_MODE=1, value 0x00F0 shows 0111_0001 on digit 1 and 0000_0011 on digit 0.
- Reset mid-operation. Assert reset while update_pending=1 and idx=2.
  - Next edge: seg=FF, an=1111, update_pending=0.
  - After release with no further load: the first frame shows 0 on digit 0 only.
